// File: rtl/mem_stage_pkg.sv
// Shared types and default sizing for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  // Bus-access FSM: IDLE takes new accesses, WAIT holds one until ack/abort.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write enable only; the
// remaining fields are captured anyway since writeback ignores them.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble_i,
  input  logic              regwrt_i,
  input  logic              ressrc_i,
  input  logic [4:0]        rd_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              regwrt_o,
  output logic              ressrc_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              regwrt_q, ressrc_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] pc4_q, alu_q, rdata_q;

  // Capture WB fields every cycle; bubble squashes the register write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrt_q <= 1'b0;
      ressrc_q <= 1'b0;
      rd_q     <= '0;
      pc4_q    <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
    end else begin
      regwrt_q <= regwrt_i & ~bubble_i;
      ressrc_q <= ressrc_i;
      rd_q     <= rd_i;
      pc4_q    <= pc4_i;
      alu_q    <= alu_i;
      rdata_q  <= rdata_i;
    end
  end

  assign regwrt_o = regwrt_q;
  assign ressrc_o = ressrc_q;
  assign rd_o     = rd_q;
  assign pc4_o    = pc4_q;
  assign alu_o    = alu_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the req/ack data bus, stalls the front end while an
// access is outstanding, aborts after TIMEOUT wait cycles, owns MEM/WB.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned accesses are
// squashed (no bus request) and flagged on sticky misalign_mem; without it
// the low two address bits are simply forced to zero.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrtMem,
  input  logic              MemWrtMem,
  input  logic              ResultSrcMem,
  input  logic [4:0]        RD_Mem,
  input  logic [DATA_W-1:0] PCplus4Mem,
  input  logic [DATA_W-1:0] WriteDataMem,
  input  logic [DATA_W-1:0] ALU_ResultMem,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              stall_mem,
  output logic              RegWrtWb,
  output logic              ResultSrcWb,
  output logic [4:0]        RD_Wb,
  output logic [DATA_W-1:0] PCplus4Wb,
  output logic [DATA_W-1:0] ALU_ResultWb,
  output logic [DATA_W-1:0] ReadDataWb,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_mem,
`endif
  output logic              err_mem
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              acc, acc_ok, mis;
  logic              req, stall, abort, done, kill;
  logic [DATA_W-1:0] rdata_wb;

  assign acc = MemWrtMem | ResultSrcMem;

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign mis       = acc & (|ALU_ResultMem[1:0]);
  assign dmem_addr = ADDR_W'(ALU_ResultMem);
  assign mis_d     = mis_q | mis;

  // Sticky misalignment flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end
  assign misalign_mem = mis_q;
`else
  assign mis       = 1'b0;
  assign dmem_addr = ADDR_W'(ALU_ResultMem) & ~ADDR_W'(3);
`endif

  assign acc_ok     = acc & ~mis;
  assign dmem_we    = MemWrtMem;
  assign dmem_wdata = WriteDataMem;

  // Next state, timeout count and bus/stall handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_ok) begin
          req = 1'b1;
          if (!dmem_ack) begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req     = acc_ok;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          req   = acc_ok;
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_d = err_q | abort;

  // Sticky bus-timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  // Request/stall are dropped the moment reset asserts, even mid-WAIT.
  assign dmem_req  = rst & req;
  assign stall_mem = rst & stall;
  assign err_mem   = err_q;

  // Only a completing access carries read data into WB.
  assign done     = req & dmem_ack;
  assign rdata_wb = done ? dmem_rdata : '0;
  assign kill     = abort | mis;

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (stall | kill),
    .regwrt_i (RegWrtMem),
    .ressrc_i (ResultSrcMem),
    .rd_i     (RD_Mem),
    .pc4_i    (PCplus4Mem),
    .alu_i    (ALU_ResultMem),
    .rdata_i  (rdata_wb),
    .regwrt_o (RegWrtWb),
    .ressrc_o (ResultSrcWb),
    .rd_o     (RD_Wb),
    .pc4_o    (PCplus4Wb),
    .alu_o    (ALU_ResultWb),
    .rdata_o  (ReadDataWb)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (default TIMEOUT=16). Inputs change 1ns
// after posedge; combinational outputs are sampled 1ns later, registered
// outputs 1ns after the next posedge.
module tb_memory_stage;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWrtMem, MemWrtMem, ResultSrcMem;
  logic [4:0]    RD_Mem;
  logic [DW-1:0] PCplus4Mem, WriteDataMem, ALU_ResultMem;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          stall_mem, RegWrtWb, ResultSrcWb, err_mem;
  logic [4:0]    RD_Wb;
  logic [DW-1:0] PCplus4Wb, ALU_ResultWb, ReadDataWb;
`ifdef MEM_MISALIGN_CHECK_EN
  logic          misalign_mem;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrtMem     (RegWrtMem),
    .MemWrtMem     (MemWrtMem),
    .ResultSrcMem  (ResultSrcMem),
    .RD_Mem        (RD_Mem),
    .PCplus4Mem    (PCplus4Mem),
    .WriteDataMem  (WriteDataMem),
    .ALU_ResultMem (ALU_ResultMem),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .stall_mem     (stall_mem),
    .RegWrtWb      (RegWrtWb),
    .ResultSrcWb   (ResultSrcWb),
    .RD_Wb         (RD_Wb),
    .PCplus4Wb     (PCplus4Wb),
    .ALU_ResultWb  (ALU_ResultWb),
    .ReadDataWb    (ReadDataWb),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_mem  (misalign_mem),
`endif
    .err_mem       (err_mem)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    RegWrtMem = 0; MemWrtMem = 0; ResultSrcMem = 0; RD_Mem = '0;
    PCplus4Mem = '0; WriteDataMem = '0; ALU_ResultMem = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic ack,
                      input logic [31:0] rdata);
    RegWrtMem = 1; MemWrtMem = 0; ResultSrcMem = 1; RD_Mem = rd;
    PCplus4Mem = 32'h100 + addr; WriteDataMem = '0; ALU_ResultMem = addr;
    dmem_ack = ack; dmem_rdata = rdata;
  endtask

  initial begin
    clr();
    rst = 0;
    // Reset: everything zero, no request even with a load pending.
    #3;
    ResultSrcMem = 1;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_regwrt", RegWrtWb, 0);
    chk("rst_err", err_mem, 0);
    chk("rst_alu", ALU_ResultWb, 0);
    clr();
    @(negedge clk);
    rst = 1;
    tick();

    // 1: zero-wait load.
    load(32'h10, 5'd5, 1, 32'hDEADBEEF);
    #1;
    chk("t1_req", dmem_req, 1);
    chk("t1_stall", stall_mem, 0);
    chk("t1_addr", dmem_addr, 32'h10);
    chk("t1_we", dmem_we, 0);
    tick();
    chk("t1_regwrt", RegWrtWb, 1);
    chk("t1_rdata", ReadDataWb, 32'hDEADBEEF);
    chk("t1_rd", RD_Wb, 5);
    chk("t1_pc4", PCplus4Wb, 32'h110);
    chk("t1_ressrc", ResultSrcWb, 1);
    clr();

    // 2: store, ack arrives after 3 stall cycles.
    MemWrtMem = 1; ALU_ResultMem = 32'h20; WriteDataMem = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall", stall_mem, 1);
      chk("t2_we", dmem_we, 1);
      chk("t2_req", dmem_req, 1);
      chk("t2_wdata", dmem_wdata, 32'h55);
      tick();
      chk("t2_regwrt", RegWrtWb, 0);
    end
    dmem_ack = 1;
    #1;
    chk("t2_ack_stall", stall_mem, 0);
    chk("t2_ack_we", dmem_we, 1);
    tick();
    chk("t2_done_regwrt", RegWrtWb, 0);
    clr();

    // 2b: load with one wait cycle -> bubble then data.
    load(32'h24, 5'd7, 0, 32'h0);
    #1;
    chk("t2b_stall", stall_mem, 1);
    tick();
    chk("t2b_bubble", RegWrtWb, 0);
    dmem_ack = 1; dmem_rdata = 32'h1234;
    #1;
    chk("t2b_ack_stall", stall_mem, 0);
    tick();
    chk("t2b_regwrt", RegWrtWb, 1);
    chk("t2b_rdata", ReadDataWb, 32'h1234);
    chk("t2b_rd", RD_Wb, 7);
    clr();

    // 3: timeout. Request cycle + 15 WAIT cycles stall, 16th WAIT cycle aborts.
    load(32'h30, 5'd9, 0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t3_stall%0d", i), stall_mem, 1);
      chk($sformatf("t3_req%0d", i), dmem_req, 1);
      tick();
    end
    chk("t3_err_before", err_mem, 0);
    #1;
    chk("t3_abort_stall", stall_mem, 0);
    chk("t3_abort_req", dmem_req, 0);
    tick();
    chk("t3_err", err_mem, 1);
    chk("t3_regwrt", RegWrtWb, 0);
    chk("t3_alu", ALU_ResultWb, 32'h30);
    clr();
    tick();
    chk("t3_err_sticky", err_mem, 1);
    // Back in IDLE: a zero-wait load goes straight through.
    load(32'h40, 5'd3, 1, 32'hCAFE);
    #1;
    chk("t3_idle_stall", stall_mem, 0);
    tick();
    chk("t3_idle_rdata", ReadDataWb, 32'hCAFE);
    clr();

    // 5: ALU op with spurious ack.
    RegWrtMem = 1; ALU_ResultMem = 32'hABCD; RD_Mem = 5'd11;
    dmem_ack = 1; dmem_rdata = 32'hFFFF;
    #1;
    chk("t5_req", dmem_req, 0);
    chk("t5_stall", stall_mem, 0);
    tick();
    chk("t5_rdata", ReadDataWb, 0);
    chk("t5_alu", ALU_ResultWb, 32'hABCD);
    chk("t5_regwrt", RegWrtWb, 1);
    clr();

    // 6: misaligned load address 0x13.
    load(32'h13, 5'd4, 1, 32'h99);
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("t6_req", dmem_req, 0);
    chk("t6_stall", stall_mem, 0);
    tick();
    chk("t6_mis", misalign_mem, 1);
    chk("t6_regwrt", RegWrtWb, 0);
`else
    chk("t6_addr", dmem_addr, 32'h10);
    chk("t6_req", dmem_req, 1);
    tick();
    chk("t6_regwrt", RegWrtWb, 1);
`endif
    clr();

    // 4: reset asserted in the second WAIT cycle.
    load(32'h50, 5'd6, 0, 32'h0);
    tick();
    tick();
    #1;
    chk("t4_wait_stall", stall_mem, 1);
    rst = 0;
    #1;
    chk("t4_req", dmem_req, 0);
    chk("t4_regwrt", RegWrtWb, 0);
    chk("t4_alu", ALU_ResultWb, 0);
    chk("t4_pc4", PCplus4Wb, 0);
    chk("t4_err", err_mem, 0);
    clr();
    tick();
    dmem_ack = 1; dmem_rdata = 32'h777;
    #1;
    chk("t4_late_req", dmem_req, 0);
    tick();
    chk("t4_late_rdata", ReadDataWb, 0);
    clr();
    @(negedge clk);
    rst = 1;
    tick();
    chk("t4_post_stall", stall_mem, 0);
    chk("t4_post_regwrt", RegWrtWb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
